// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column drive, 2-flop row sync, press/release debounce,
// single-cycle key events with linear key code and optional auto-repeat.
module keypad_scan_ctrl #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DWELL_CYC  = 27,
   parameter int DB_CYC     = 270000,
   parameter int REPEAT_EN  = 0,
   parameter int REPEAT_DLY = 13500000,
   parameter int REPEAT_PER = 2700000,
   parameter int CODE_W     = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ROWS-1:0]   filas_raw,
   output logic [COLS-1:0]   columnas,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              key_release,
   output logic              multi_err
);
   localparam int DW_W   = $clog2(DWELL_CYC + 1);
   localparam int DB_W   = $clog2(DB_CYC + 1);
   localparam int RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   localparam logic [1:0] S_SCAN = 2'd0;
   localparam logic [1:0] S_DEB  = 2'd1;
   localparam logic [1:0] S_HELD = 2'd2;
   localparam logic [1:0] S_REL  = 2'd3;

   logic [1:0]        rst_q;
   logic              rst;
   logic [ROWS-1:0]   row_s1, rows;
   logic [1:0]        state;
   logic [DW_W-1:0]   dw_cnt;
   logic [DB_W-1:0]   db_cnt;
   logic [RP_W-1:0]   rp_cnt, rp_tgt;
   logic              rp_first;
   logic [ROWS-1:0]   cand_mask;
   logic [CODE_W-1:0] cand_code, code_now;
   logic [COLS-1:0]   col_next;
   logic              rows_zero, rows_one, rel_done;
   int                row_idx, col_idx;

   // Reset asserts immediately but releases two clocks later, aligned to clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_q <= 2'b11;
      else       rst_q <= {rst_q[0], 1'b0};
   end
   assign rst = rst_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1 <= '0;
         rows   <= '0;
      end else begin
         row_s1 <= filas_raw;
         rows   <= row_s1;
      end
   end

   always_comb begin
      row_idx = 0;
      col_idx = 0;
      for (int i = 0; i < ROWS; i++) if (rows[i]) row_idx = i;
      for (int j = 0; j < COLS; j++) if (columnas[j]) col_idx = j;
      code_now  = CODE_W'(row_idx * COLS + col_idx);
      col_next  = {columnas[COLS-2:0], columnas[COLS-1]};
      rows_zero = (rows == '0);
      rows_one  = !rows_zero && ((rows & (rows - ROWS'(1))) == '0);
      rel_done  = (state == S_REL) && ((rows & cand_mask) == '0) &&
                  (db_cnt == DB_W'(DB_CYC - 1));
      rp_tgt    = rp_first ? RP_W'(REPEAT_DLY - 1) : RP_W'(REPEAT_PER - 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_SCAN;
         columnas    <= COLS'(1);
         dw_cnt      <= '0;
         db_cnt      <= '0;
         rp_cnt      <= '0;
         rp_first    <= 1'b0;
         cand_mask   <= '0;
         cand_code   <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_held    <= 1'b0;
         key_release <= 1'b0;
         multi_err   <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         multi_err   <= 1'b0;
         case (state)
            S_SCAN: begin
               if (dw_cnt == DW_W'(DWELL_CYC - 1)) begin
                  dw_cnt <= '0;
                  if (rows_one) begin
                     cand_mask <= rows;
                     cand_code <= code_now;
                     db_cnt    <= '0;
                     state     <= S_DEB;
                  end else begin
                     // Ghosted multi-row reads are skipped like an empty column.
                     columnas  <= col_next;
                     multi_err <= !rows_zero;
                  end
               end else begin
                  dw_cnt <= dw_cnt + DW_W'(1);
               end
            end
            S_DEB: begin
               if (rows != cand_mask) begin
                  columnas <= col_next;
                  db_cnt   <= '0;
                  state    <= S_SCAN;
               end else if (db_cnt == DB_W'(DB_CYC - 1)) begin
                  key_code  <= cand_code;
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  db_cnt    <= '0;
                  rp_cnt    <= '0;
                  rp_first  <= 1'b1;
                  state     <= S_HELD;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            S_HELD: begin
               if (rows_zero) begin
                  db_cnt <= '0;
                  state  <= S_REL;
               end
            end
            default: begin
               if ((rows & cand_mask) != '0) begin
                  state <= S_HELD;
               end else if (rel_done) begin
                  key_held    <= 1'b0;
                  key_release <= 1'b1;
                  columnas    <= col_next;
                  dw_cnt      <= '0;
                  db_cnt      <= '0;
                  state       <= S_SCAN;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
         endcase
         // Repeat timer runs from accept through release debounce; a release wins a tie.
         if (key_held) begin
            if (rp_cnt == rp_tgt) begin
               rp_cnt   <= '0;
               rp_first <= 1'b0;
               if (REPEAT_EN != 0 && !rel_done) key_valid <= 1'b1;
            end else begin
               rp_cnt <= rp_cnt + RP_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized keypad-matrix stimulus with a scoreboard of expected key events.
module tb_keypad_scan_ctrl;
   localparam int ROWS = 4, COLS = 4, DWELL = 4, DB = 8, RDLY = 20, RPER = 10;
   localparam int K_VALID = 0, K_REL = 1, K_MULTI = 2;
   localparam int REL_LAT = 2 + 1 + DB;   // sync + idle detect + debounce

   typedef struct {
      int kind;
      int code;
      int t;
   } ev_t;

   logic clk, reset;
   logic [ROWS-1:0] filas_raw;
   logic [COLS-1:0] columnas;
   logic [3:0] key_code;
   logic key_valid, key_held, key_release, multi_err;
   logic [ROWS-1:0][COLS-1:0] keys;

   int cyc = 0;
   int checks = 0;
   int passes = 0;
   bit mon_en = 0;
   ev_t exp_q[$];

   keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .DWELL_CYC(DWELL), .DB_CYC(DB),
                      .REPEAT_EN(1), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)) dut (
      .clk(clk), .reset(reset), .filas_raw(filas_raw), .columnas(columnas),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
      .key_release(key_release), .multi_err(multi_err));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   // A row reads high when a pressed key sits on the currently driven column.
   always_comb begin
      filas_raw = '0;
      for (int r = 0; r < ROWS; r++) filas_raw[r] = |(keys[r] & columnas);
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic push(input int kind, input int code, input int t);
      ev_t e;
      e.kind = kind; e.code = code; e.t = t;
      exp_q.push_back(e);
   endtask

   task automatic handle(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         if (e.code >= 0) chk("event_code", int'(key_code), e.code);
         if (e.t >= 0) chk("event_cycle", cyc, e.t);
         if (kind == K_VALID) chk("held_on_valid", int'(key_held), 1);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (key_valid && key_release) chk("valid_and_release", 1, 0);
         if (key_valid) handle(K_VALID);
         if (key_release) handle(K_REL);
         if (multi_err) handle(K_MULTI);
      end
   end

   task automatic wait_held(output int a);
      a = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (key_held) begin
            a = cyc;
            break;
         end
      end
      if (a < 0) chk("timeout_key_held", 0, 1);
   endtask

   task automatic key_trial(input int r, input int c, input int bph, input int btog,
                            input int hold, input int rel_tog);
      int a, x, rr, ph[$];
      push(K_VALID, r * COLS + c, -1);
      for (int i = 0; i < btog; i++) begin
         keys[r][c] = ~keys[r][c];
         repeat (bph) @(negedge clk);
      end
      keys[r][c] = 1'b1;
      wait_held(a);
      if (a < 0) return;
      chk("col_frozen", int'(columnas), 1 << c);
      // Plan the whole release schedule now so repeat expectations precede them.
      for (int i = 0; i < 2 * rel_tog; i++) ph.push_back($urandom_range(1, 4));
      x = a + hold;
      foreach (ph[i]) x += ph[i];
      rr = x + REL_LAT;
      for (int t = a + RDLY; t < rr; t += RPER) push(K_VALID, r * COLS + c, t);
      push(K_REL, r * COLS + c, rr);
      repeat (hold) @(negedge clk);
      foreach (ph[i]) begin
         keys[r][c] = ~keys[r][c];
         repeat (ph[i]) @(negedge clk);
      end
      keys[r][c] = 1'b0;
      while (cyc < rr) @(negedge clk);
      chk("held_after_release", int'(key_held), 0);
      chk("scan_resume_col", int'(columnas), 1 << ((c + 1) % COLS));
      repeat ($urandom_range(3, 12)) @(negedge clk);
   endtask

   initial begin
      int c0, n, e0, c, prev;
      bit found;
      reset = 1;
      keys = '0;
      repeat (3) @(negedge clk);
      chk("rst_columnas", int'(columnas), 1);
      chk("rst_key_code", int'(key_code), 0);
      chk("rst_key_held", int'(key_held), 0);
      chk("rst_pulses", int'({key_valid, key_release, multi_err}), 0);
      reset = 0;
      c0 = cyc;
      mon_en = 1;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         n = cyc - c0 - 2;
         chk("idle_scan_col", int'(columnas), 1 << ((n <= 0) ? 0 : (n / DWELL) % COLS));
      end

      key_trial(2, 1, 1, 0, 40, 0);
      key_trial(0, 3, 3, 10, 12, 3);
      for (int t = 0; t < 5; t++)
         key_trial($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
                   $urandom_range(1, 3), 2 * $urandom_range(0, 4),
                   $urandom_range(5, 45), $urandom_range(0, 3));

      // Two rows on one column: rejected as ghosting, scan moves on.
      c = $urandom_range(0, COLS - 1);
      found = 0;
      prev = int'(columnas);
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (int'(columnas) == (1 << c) && prev != (1 << c)) found = 1;
         prev = int'(columnas);
      end
      if (!found) chk("timeout_multi_col", 0, 1);
      e0 = cyc;
      push(K_MULTI, -1, e0 + DWELL);
      keys[0][c] = 1'b1;
      keys[3][c] = 1'b1;
      for (int i = 0; i < 50 && int'(columnas) == (1 << c); i++) @(negedge clk);
      keys = '0;
      chk("multi_rotates", int'(columnas), 1 << ((c + 1) % COLS));
      repeat (40) @(negedge clk);

      // Reset while a key is held: no release event may follow.
      push(K_VALID, 1 * COLS + 2, -1);
      keys[1][2] = 1'b1;
      wait_held(e0);
      repeat (5) @(negedge clk);
      #2;
      reset = 1;
      mon_en = 0;
      exp_q.delete();
      keys = '0;
      #1;
      chk("midrst_columnas", int'(columnas), 1);
      chk("midrst_key_held", int'(key_held), 0);
      chk("midrst_key_code", int'(key_code), 0);
      repeat (2) @(negedge clk);
      reset = 0;
      mon_en = 1;
      repeat (40) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
